// File: rtl/pe_array_sequencer_if.sv
// Host/array handshake bundle for the PE array sequencer.
// The slave modport is the sequencer; the master modport is the host plus the array's ready line.
interface pe_array_sequencer_if #(
   parameter int COMMAND_WIDTH = 4,
   parameter int STEP_W        = 8
);
   logic                     start;
   logic [STEP_W-1:0]        num_steps;
   logic                     abort;
   logic                     ready;
   logic [COMMAND_WIDTH-1:0] command_to_execute;
   logic [1:0]               shift_direction;
   logic                     array_ack;
   logic                     busy;
   logic                     done;
   logic                     error;
   logic [STEP_W-1:0]        step_count;

   modport master (
      output start, num_steps, abort, ready,
      input  command_to_execute, shift_direction, array_ack, busy, done, error, step_count
   );

   modport slave (
      input  start, num_steps, abort, ready,
      output command_to_execute, shift_direction, array_ack, busy, done, error, step_count
   );
endinterface

// File: rtl/pe_array_sequencer.sv
// Walks the systolic multiply sequence LOAD, (MAC, SHIFT_A, SHIFT_B) x N on the PE array bus,
// closing a ready/ack handshake per command with a per-command timeout and synchronous abort.
module pe_array_sequencer #(
   parameter int COMMAND_WIDTH  = 4,
   parameter int STEP_W         = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic CLK,
   input logic RST_N,
   pe_array_sequencer_if.slave bus
);

   localparam logic [COMMAND_WIDTH-1:0] CMD_NOP     = COMMAND_WIDTH'(0);
   localparam logic [COMMAND_WIDTH-1:0] CMD_LOAD    = COMMAND_WIDTH'(1);
   localparam logic [COMMAND_WIDTH-1:0] CMD_MAC     = COMMAND_WIDTH'(2);
   localparam logic [COMMAND_WIDTH-1:0] CMD_SHIFT_A = COMMAND_WIDTH'(3);
   localparam logic [COMMAND_WIDTH-1:0] CMD_SHIFT_B = COMMAND_WIDTH'(4);

   localparam logic [1:0] DIR_UP   = 2'd0;
   localparam logic [1:0] DIR_LEFT = 2'd2;

   localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_ACK,
      S_FIN
   } state_t;

   state_t                   state;
   logic [COMMAND_WIDTH-1:0] cur_cmd;
   logic [STEP_W-1:0]        n_latched;
   logic [WAIT_W-1:0]        wait_count;

   logic [COMMAND_WIDTH-1:0] next_cmd;
   logic                     seq_end;
   logic [STEP_W-1:0]        step_next;

   function automatic logic [1:0] dir_for(input logic [COMMAND_WIDTH-1:0] cmd);
      return (cmd == CMD_SHIFT_A) ? DIR_LEFT : DIR_UP;
   endfunction

   // cur_cmd remembers the acknowledged command because the bus shows NOP during ACK
   always_comb begin
      next_cmd  = CMD_MAC;
      seq_end   = 1'b0;
      step_next = bus.step_count + STEP_W'(1);
      case (cur_cmd)
         CMD_LOAD:    seq_end  = (n_latched == '0);
         CMD_MAC:     next_cmd = CMD_SHIFT_A;
         CMD_SHIFT_A: next_cmd = CMD_SHIFT_B;
         CMD_SHIFT_B: seq_end  = (step_next == n_latched);
         default:     seq_end  = 1'b1;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state                  <= S_IDLE;
         cur_cmd                <= CMD_NOP;
         n_latched              <= '0;
         wait_count             <= '0;
         bus.command_to_execute <= CMD_NOP;
         bus.shift_direction    <= DIR_UP;
         bus.array_ack          <= 1'b0;
         bus.busy               <= 1'b0;
         bus.done               <= 1'b0;
         bus.error              <= 1'b0;
         bus.step_count         <= '0;
      end else begin
         bus.array_ack <= 1'b0;
         bus.done      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state                  <= S_ISSUE;
                  cur_cmd                <= CMD_LOAD;
                  bus.command_to_execute <= CMD_LOAD;
                  bus.shift_direction    <= DIR_UP;
                  bus.busy               <= 1'b1;
                  n_latched              <= bus.num_steps;
                  bus.step_count         <= '0;
                  bus.error              <= 1'b0;
                  wait_count             <= '0;
               end
            end
            // Abort outranks ready, which outranks the timeout
            S_ISSUE: begin
               if (bus.abort) begin
                  state                  <= S_IDLE;
                  bus.command_to_execute <= CMD_NOP;
                  bus.shift_direction    <= DIR_UP;
                  bus.busy               <= 1'b0;
               end else if (bus.ready) begin
                  state                  <= S_ACK;
                  bus.command_to_execute <= CMD_NOP;
                  bus.shift_direction    <= DIR_UP;
                  bus.array_ack          <= 1'b1;
               end else if (wait_count == WAIT_LAST) begin
                  state                  <= S_IDLE;
                  bus.command_to_execute <= CMD_NOP;
                  bus.shift_direction    <= DIR_UP;
                  bus.busy               <= 1'b0;
                  bus.error              <= 1'b1;
               end else begin
                  wait_count <= wait_count + WAIT_W'(1);
               end
            end
            S_ACK: begin
               if (bus.abort) begin
                  state    <= S_IDLE;
                  bus.busy <= 1'b0;
               end else begin
                  if (cur_cmd == CMD_SHIFT_B) begin
                     bus.step_count <= step_next;
                  end
                  if (seq_end) begin
                     state    <= S_FIN;
                     bus.done <= 1'b1;
                  end else begin
                     state                  <= S_ISSUE;
                     cur_cmd                <= next_cmd;
                     bus.command_to_execute <= next_cmd;
                     bus.shift_direction    <= dir_for(next_cmd);
                     wait_count             <= '0;
                  end
               end
            end
            S_FIN: begin
               state    <= S_IDLE;
               bus.busy <= 1'b0;
            end
            default: begin
               state                  <= S_IDLE;
               bus.command_to_execute <= CMD_NOP;
               bus.shift_direction    <= DIR_UP;
               bus.busy               <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Scoreboard bench for pe_array_sequencer: directed runs push expected commands and done events,
// a monitor pops them whenever a new command or a done pulse appears on the bus.
module tb_pe_array_sequencer;

   localparam int CW = 4;
   localparam int SW = 8;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   pe_array_sequencer_if #(.COMMAND_WIDTH(CW), .STEP_W(SW)) bus ();

   pe_array_sequencer #(
      .COMMAND_WIDTH (CW),
      .STEP_W        (SW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .CLK  (clk),
      .RST_N(rst_n),
      .bus  (bus)
   );

   typedef struct packed {
      logic [3:0] cmd;
      logic [1:0] dir;
   } cmd_exp_t;

   cmd_exp_t   exp_cmds[$];
   int         exp_done[$];
   int         n_compared   = 0;
   int         n_mismatched = 0;
   int         ack_count    = 0;
   int         done_count   = 0;
   int         resp_mode    = 0;
   int         resp_delay   = 3;
   bit         ready_in_ack = 1'b0;
   logic [3:0] mon_prev_cmd;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic push_cmd(input int cmd, input int dir);
      cmd_exp_t e;
      e.cmd = 4'(cmd);
      e.dir = 2'(dir);
      exp_cmds.push_back(e);
   endtask

   task automatic apply_stimulus(input int n);
      @(negedge clk);
      bus.start     = 1'b1;
      bus.num_steps = SW'(n);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int k;
      k = 0;
      while (bus.busy === 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check_output({name, "_idle_in_budget"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic end_of_run(input string name, input int acks, input int dones);
      check_output({name, "_acks"}, ack_count, acks);
      check_output({name, "_dones"}, done_count, dones);
      check_output({name, "_cmds_left"}, exp_cmds.size(), 0);
      check_output({name, "_done_left"}, exp_done.size(), 0);
      exp_cmds.delete();
      exp_done.delete();
      ack_count  = 0;
      done_count = 0;
   endtask

   // Monitor: a command rising out of NOP is a new issue; done pulses pop the done queue
   initial begin
      cmd_exp_t e;
      int       s;
      mon_prev_cmd = '0;
      forever begin
         @(negedge clk);
         if (bus.command_to_execute != 4'd0 && mon_prev_cmd == 4'd0) begin
            if (exp_cmds.size() == 0) begin
               n_compared++;
               n_mismatched++;
               $display("[TB] FAIL unexpected_cmd: got %0d, expected none", bus.command_to_execute);
            end else begin
               e = exp_cmds.pop_front();
               check_output("cmd", 32'(bus.command_to_execute), 32'(e.cmd));
               check_output("dir", 32'(bus.shift_direction), 32'(e.dir));
            end
         end
         mon_prev_cmd = bus.command_to_execute;
         if (bus.array_ack === 1'b1) begin
            ack_count++;
            check_output("ack_cmd_nop", 32'(bus.command_to_execute), 32'd0);
         end
         if (bus.done === 1'b1) begin
            done_count++;
            if (exp_done.size() == 0) begin
               n_compared++;
               n_mismatched++;
               $display("[TB] FAIL unexpected_done: got 1, expected 0");
            end else begin
               s = exp_done.pop_front();
               check_output("done_step_count", 32'(bus.step_count), 32'(s));
               check_output("done_error", 32'(bus.error), 32'd0);
            end
         end
      end
   end

   // Array model: 0 = ready low, 1 = pulse after resp_delay ISSUE cycles, 2 = held high, 3 = manual
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(negedge clk);
         case (resp_mode)
            0: bus.ready = 1'b0;
            1: begin
               if (bus.command_to_execute != 4'd0) begin
                  cnt++;
                  bus.ready = (cnt == resp_delay);
               end else begin
                  cnt = 0;
                  bus.ready = ready_in_ack && (bus.array_ack === 1'b1);
               end
            end
            2: bus.ready = 1'b1;
            default: ;
         endcase
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] simulation watchdog expired");
   end

   initial begin
      int k;
      bus.start     = 1'b0;
      bus.num_steps = '0;
      bus.abort     = 1'b0;
      bus.ready     = 1'b0;

      // Reset values
      repeat (2) @(negedge clk);
      check_output("rst_cmd", 32'(bus.command_to_execute), 32'd0);
      check_output("rst_dir", 32'(bus.shift_direction), 32'd0);
      check_output("rst_ack", 32'(bus.array_ack), 32'd0);
      check_output("rst_busy", 32'(bus.busy), 32'd0);
      check_output("rst_done", 32'(bus.done), 32'd0);
      check_output("rst_error", 32'(bus.error), 32'd0);
      check_output("rst_step", 32'(bus.step_count), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_output("post_rst_busy", 32'(bus.busy), 32'd0);

      $display("[TB] reset during SHIFT_A wait");
      resp_mode  = 1;
      resp_delay = 3;
      push_cmd(1, 0);
      push_cmd(2, 0);
      push_cmd(3, 2);
      apply_stimulus(1);
      k = 0;
      while (bus.command_to_execute !== 4'd3 && k < 50) begin
         @(negedge clk);
         k++;
      end
      check_output("reach_shift_a", 32'(bus.command_to_execute), 32'd3);
      rst_n = 1'b0;
      #1;
      check_output("midrst_cmd", 32'(bus.command_to_execute), 32'd0);
      check_output("midrst_dir", 32'(bus.shift_direction), 32'd0);
      check_output("midrst_busy", 32'(bus.busy), 32'd0);
      check_output("midrst_ack", 32'(bus.array_ack), 32'd0);
      resp_mode = 0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_output("midrst_step", 32'(bus.step_count), 32'd0);
      end_of_run("midrst", 2, 0);

      $display("[TB] N=2, ready three cycles into each issue");
      resp_mode  = 1;
      resp_delay = 3;
      push_cmd(1, 0);
      push_cmd(2, 0);
      push_cmd(3, 2);
      push_cmd(4, 0);
      push_cmd(2, 0);
      push_cmd(3, 2);
      push_cmd(4, 0);
      exp_done.push_back(2);
      apply_stimulus(2);
      check_output("n2_busy", 32'(bus.busy), 32'd1);
      wait_idle("n2", 200);
      check_output("n2_step", 32'(bus.step_count), 32'd2);
      check_output("n2_error", 32'(bus.error), 32'd0);
      end_of_run("n2", 7, 1);
      resp_mode = 0;

      $display("[TB] N=0 with ready held high");
      resp_mode = 2;
      push_cmd(1, 0);
      exp_done.push_back(0);
      apply_stimulus(0);
      check_output("n0_load", 32'(bus.command_to_execute), 32'd1);
      check_output("n0_busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
      check_output("n0_ack", 32'(bus.array_ack), 32'd1);
      @(negedge clk);
      check_output("n0_done", 32'(bus.done), 32'd1);
      check_output("n0_fin_busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
      check_output("n0_idle_busy", 32'(bus.busy), 32'd0);
      check_output("n0_idle_done", 32'(bus.done), 32'd0);
      resp_mode = 0;
      end_of_run("n0", 1, 1);

      $display("[TB] timeout with ready low");
      push_cmd(1, 0);
      apply_stimulus(3);
      repeat (7) @(negedge clk);
      check_output("to_load_held", 32'(bus.command_to_execute), 32'd1);
      check_output("to_busy_held", 32'(bus.busy), 32'd1);
      @(negedge clk);
      check_output("to_cmd", 32'(bus.command_to_execute), 32'd0);
      check_output("to_busy", 32'(bus.busy), 32'd0);
      check_output("to_error", 32'(bus.error), 32'd1);
      resp_mode = 2;
      push_cmd(1, 0);
      exp_done.push_back(0);
      apply_stimulus(0);
      check_output("to_error_cleared", 32'(bus.error), 32'd0);
      wait_idle("to_clear", 20);
      resp_mode = 0;
      end_of_run("to", 1, 1);

      $display("[TB] abort together with ready during MAC");
      @(negedge clk);
      resp_mode = 3;
      bus.ready = 1'b0;
      push_cmd(1, 0);
      push_cmd(2, 0);
      apply_stimulus(1);
      bus.ready = 1'b1;
      @(negedge clk);
      check_output("ab_load_ack", 32'(bus.array_ack), 32'd1);
      bus.ready = 1'b0;
      @(negedge clk);
      check_output("ab_mac", 32'(bus.command_to_execute), 32'd2);
      bus.ready = 1'b1;
      bus.abort = 1'b1;
      @(negedge clk);
      bus.ready = 1'b0;
      bus.abort = 1'b0;
      check_output("ab_cmd", 32'(bus.command_to_execute), 32'd0);
      check_output("ab_busy", 32'(bus.busy), 32'd0);
      check_output("ab_ack", 32'(bus.array_ack), 32'd0);
      check_output("ab_error", 32'(bus.error), 32'd0);
      @(negedge clk);
      end_of_run("ab", 1, 0);

      $display("[TB] start and abort together in idle");
      resp_mode = 2;
      push_cmd(1, 0);
      exp_done.push_back(0);
      bus.abort = 1'b1;
      apply_stimulus(0);
      bus.abort = 1'b0;
      check_output("sa_busy", 32'(bus.busy), 32'd1);
      wait_idle("sa", 20);
      resp_mode = 0;
      end_of_run("sa", 1, 1);

      $display("[TB] ready in idle and ack, start while busy");
      @(negedge clk);
      resp_mode = 3;
      bus.ready = 1'b1;
      repeat (3) @(negedge clk);
      check_output("ri_busy", 32'(bus.busy), 32'd0);
      check_output("ri_cmd", 32'(bus.command_to_execute), 32'd0);
      bus.ready    = 1'b0;
      resp_delay   = 2;
      ready_in_ack = 1'b1;
      resp_mode    = 1;
      push_cmd(1, 0);
      push_cmd(2, 0);
      push_cmd(3, 2);
      push_cmd(4, 0);
      exp_done.push_back(1);
      apply_stimulus(1);
      repeat (2) @(negedge clk);
      bus.start     = 1'b1;
      bus.num_steps = SW'(5);
      @(negedge clk);
      bus.start = 1'b0;
      wait_idle("sb", 200);
      check_output("sb_step", 32'(bus.step_count), 32'd1);
      ready_in_ack = 1'b0;
      resp_mode    = 0;
      end_of_run("sb", 4, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/pe_array_sequencer.md
# pe_array_sequencer

Command initiator for the processing-element mesh. It accepts a start request from the host with a step count and drives the mesh's shared `command_to_execute` / `shift_direction` bus. It closes the `ready` / `array_ack` handshake for each command, walking the fixed LOAD → (MAC, SHIFT_A, SHIFT_B) × N sequence of a systolic matrix multiply. It sits between the host/top-level control and the PE array, one instance per array.

## Interface
Parameters:
- `COMMAND_WIDTH`, 4: width of `command_to_execute`.
- `STEP_W`, 8: width of step count and step counter.
- `TIMEOUT_CYCLES`, 1024: maximum cycles to wait for `ready` per command (≥2).

Ports:
- `CLK`  in  1  sole clock; all state updates on rising edge.
- `RST_N`  in  1  reset; asynchronous, active-low.
- `start`  in  1  one-cycle request; honoured only in IDLE.
- `num_steps`  in  STEP_W  MAC/shift iterations; sampled with `start`.
- `abort`  in  1  synchronous abort of the running sequence.
- `ready`  in  1  array has completed the current command.
- `command_to_execute`  out  COMMAND_WIDTH  command to the array (registered).
- `shift_direction`  out  2  shift direction for SHIFT commands (registered).
- `array_ack`  out  1  one-cycle acknowledge of `ready` (registered).
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle pulse on successful completion.
- `error`  out  1  sticky timeout flag; cleared by the next accepted `start`.
- `step_count`  out  STEP_W  completed iterations of the current or last run.

## Operation
- Command codes: NOP=0, LOAD=1, MAC=2, SHIFT_A=3, SHIFT_B=4. Codes 5–15 are never driven.
- Directions: up=0, down=1, left=2, right=3. SHIFT_A uses left (2). SHIFT_B uses up (0). All other commands drive 0.
- States:
  - IDLE: outputs NOP, `busy`=0.
  - ISSUE: command held stable and waiting for `ready`.
  - ACK: `array_ack`=1, command=NOP.
  - FIN: `done`=1 for one cycle, then IDLE.
- IDLE + `start` → ISSUE with LOAD. Latch `num_steps`, clear `step_count` and `error`.
- ISSUE + `ready`=1 → ACK. ACK → ISSUE with the next command in sequence, or FIN if the sequence is exhausted.
- Sequence: LOAD, then N repetitions of MAC, SHIFT_A, SHIFT_B.
  - `step_count` increments in the ACK cycle of each SHIFT_B.
  - With N=0, the run is LOAD only, then FIN.
- Timeout: a wait counter clears on entry to ISSUE and increments each ISSUE cycle with `ready`=0. Reaching TIMEOUT_CYCLES → set `error`, go to IDLE, no `done`.
- `abort`=1 in any non-IDLE state → IDLE next cycle, no `array_ack`, no `done`, `error` unchanged. Abort wins over a simultaneous `ready`.
- `start` while not IDLE is ignored. `start` and `abort` together in IDLE: `abort` has no effect and `start` is accepted.
- `ready` is ignored outside ISSUE.
- Counter arithmetic is unsigned. `step_count` never exceeds the latched N, so no wrap.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state IDLE;
  - `command_to_execute`=0, `shift_direction`=0;
  - `array_ack`=0, `busy`=0, `done`=0, `error`=0;
  - `step_count`=0;
  - wait counter 0.
- Reset mid-run discards the sequence immediately; no ack or done follows.
- `start` sampled at edge t → LOAD and `busy`=1 visible after edge t (cycle t+1).
- `ready` sampled high at edge c in ISSUE → `array_ack`=1 and command=NOP during cycle c+1. The next command appears in cycle c+2.
- Each command costs at least 2 cycles. With immediate `ready`, a run occupies 2·(1+3N) cycles plus 1 FIN cycle.
- `busy` is high in ISSUE, ACK and FIN. `done` is high only in FIN.
- The array must not reassert `ready` for the new command before seeing the ack; the sequencer does not sample `ready` in ACK.

## Test plan
- Reset with `RST_N`=0 mid-run (during SHIFT_A wait) → all outputs 0 within the same cycle, state IDLE; a later `start` works normally.
- `start`, N=2, `ready` asserted 3 cycles into every ISSUE → command trace 1,2,3,4,2,3,4 with directions 0,0,2,0,0,2,0. Exactly 7 `array_ack` pulses, `step_count` ends at 2, a single `done` pulse, `error`=0.
- `start`, N=0, `ready` held high → LOAD for 1 cycle, ack, FIN: `done` three cycles after start is sampled, `step_count`=0.
- TIMEOUT_CYCLES=8, `ready` held low → LOAD held 8 cycles, then IDLE, `error`=1, no `done`. The next `start` clears `error`.
- `abort` asserted in the same cycle `ready` rises during MAC → no `array_ack`, IDLE, NOP next cycle, `busy`=0.
- `start` pulsed while busy, plus `ready` pulsed while in IDLE or ACK → no effect on sequence, trace or ack count.
